// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the loadable program memory with fetch port.
package prog_mem_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] HALT_WORD = 8'hFF;

endpackage

// File: rtl/prog_mem_array.sv
// Program storage: synchronous write, registered read, per-word written flags.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written_reg;
  logic [DATA_W-1:0] word_reg;
  logic              hit_reg;

  logic             wr_in_range;
  logic             rd_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];

  // Data array is deliberately left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      word_reg <= mem[rd_idx];
    end
  end

  // A write in the same cycle as a clear survives, so the new program keeps it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written_reg <= '0;
    end else begin
      if (clear) begin
        written_reg <= '0;
      end
      if (wr_en && wr_in_range) begin
        written_reg[wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_reg <= 1'b0;
    end else if (rd_en) begin
      hit_reg <= rd_in_range && written_reg[rd_idx];
    end
  end

  assign rd_data = hit_reg ? word_reg : FILL;

endmodule

// File: rtl/prog_mem_fetch.sv
// Loadable instruction memory: LOAD/RUN/DRAIN mode control, load counter and
// a one-cycle valid/ready fetch port in front of prog_mem_array.
module prog_mem_fetch
  import prog_mem_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b1}}
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_start_i,
  input  logic              load_done_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_oob_o,
  input  logic              rsp_ready_i,
  output logic              running_o,
  output logic [ADDR_W:0]   load_count_o
);

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  state_t          state_reg;
  state_t          state_next;
  logic            rsp_valid_reg;
  logic            rsp_oob_reg;
  logic [ADDR_W:0] load_count_reg;

  logic rsp_free;
  logic req_ready;
  logic accept;
  logic clear_prog;
  logic wr_accept;

  assign rsp_free  = !rsp_valid_reg || rsp_ready_i;
  assign wr_accept = (state_reg == LOAD) && wr_en_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    clear_prog = 1'b0;
    req_ready  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      LOAD: begin
        if (load_done_i) begin
          state_next = RUN;
        end else if (load_start_i) begin
          clear_prog = 1'b1;
        end
      end
      RUN: begin
        req_ready = rsp_free;
        accept    = req_valid_i && rsp_free;
        // A fetch accepted alongside load_start leaves a response to drain.
        if (load_start_i) begin
          if (rsp_free && !accept) begin
            state_next = LOAD;
            clear_prog = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rsp_free) begin
          state_next = LOAD;
          clear_prog = 1'b1;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      load_count_reg <= '0;
    end else if (clear_prog) begin
      load_count_reg <= wr_accept ? (ADDR_W + 1)'(1) : '0;
    end else if (wr_accept && (load_count_reg != COUNT_MAX)) begin
      load_count_reg <= load_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rsp_valid_reg <= 1'b0;
      rsp_oob_reg   <= 1'b0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_oob_reg   <= ({1'b0, req_addr_i} >= DEPTH_L);
    end else if (rsp_ready_i) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  prog_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .FILL   (FILL)
  ) u_array (
    .clk     (clk_i),
    .rst     (reset_i),
    .clear   (clear_prog),
    .wr_en   (wr_accept),
    .wr_addr (wr_addr_i),
    .wr_data (wr_data_i),
    .rd_en   (accept),
    .rd_addr (req_addr_i),
    .rd_data (rsp_data_o)
  );

  assign req_ready_o  = req_ready;
  assign rsp_valid_o  = rsp_valid_reg;
  assign rsp_oob_o    = rsp_oob_reg;
  assign running_o    = (state_reg == RUN);
  assign load_count_o = load_count_reg;

endmodule

// File: tb/tb_prog_mem_fetch.sv
// Self-checking bench for prog_mem_fetch: directed scenarios plus a randomized
// fetch run checked against a word-level memory model.
module tb_prog_mem_fetch;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;

  logic              clk = 1'b0;
  logic              reset_i = 1'b0;
  logic              load_start_i = 1'b0;
  logic              load_done_i = 1'b0;
  logic              wr_en_i = 1'b0;
  logic [ADDR_W-1:0] wr_addr_i = '0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              req_valid_i = 1'b0;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic              req_ready_o;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_oob_o;
  logic              rsp_ready_i = 1'b0;
  logic              running_o;
  logic [ADDR_W:0]   load_count_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_mem [256];
  bit         m_wr  [256];

  always #5 clk = ~clk;

  prog_mem_fetch #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .load_start_i (load_start_i),
    .load_done_i  (load_done_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .req_valid_i  (req_valid_i),
    .req_addr_i   (req_addr_i),
    .req_ready_o  (req_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_oob_o    (rsp_oob_o),
    .rsp_ready_i  (rsp_ready_i),
    .running_o    (running_o),
    .load_count_o (load_count_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] exp_word(int a);
    if (a < DEPTH && m_wr[a]) return m_mem[a];
    return 8'hFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    wr_en_i = 1'b1;
    wr_addr_i = 8'(a);
    wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
    if (a < DEPTH) begin
      m_mem[a] = d;
      m_wr[a] = 1'b1;
    end
  endtask

  task automatic pulse_done();
    load_done_i = 1'b1;
    tick();
    load_done_i = 1'b0;
  endtask

  task automatic pulse_start();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid_o); end
    checks++; if (rsp_data_o !== 8'hFF) begin errors++; $display("FAIL reset_rsp_data got %h exp ff", rsp_data_o); end
    checks++; if (rsp_oob_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_oob got %b exp 0", rsp_oob_o); end
    checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running_o); end
    checks++; if (load_count_o !== 9'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", load_count_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready_o); end
    reset_i = 1'b0;
    model_clear();
    tick();
    $display("test_reset done");
  endtask

  task automatic test_load_fetch();
    logic [7:0] prog [4];
    prog = '{8'hC1, 8'h90, 8'hC2, 8'h92};
    for (int i = 0; i < 4; i++) do_write(i, prog[i]);
    checks++; if (load_count_o !== 9'd4) begin errors++; $display("FAIL load_count got %0d exp 4", load_count_o); end
    pulse_done();
    checks++; if (running_o !== 1'b1) begin errors++; $display("FAIL run_entry running got %b exp 1", running_o); end
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1;
      req_addr_i = 8'(i);
      tick();
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== prog[i]) begin
        errors++; $display("FAIL fetch_seq addr %0d got v=%b d=%h exp v=1 d=%h", i, rsp_valid_o, rsp_data_o, prog[i]);
      end
      $display("fetch addr=%0d data=%h", i, rsp_data_o);
    end
    req_valid_i = 1'b0;
    tick();
    checks++; if (rsp_valid_o !== 1'b0 || rsp_data_o !== 8'h92) begin
      errors++; $display("FAIL consume_hold got v=%b d=%h exp v=0 d=92", rsp_valid_o, rsp_data_o);
    end
  endtask

  task automatic test_fill();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i = 8'd10;
    tick();
    checks++; if (rsp_data_o !== 8'hFF || rsp_oob_o !== 1'b0) begin
      errors++; $display("FAIL unwritten_10 got d=%h oob=%b exp d=ff oob=0", rsp_data_o, rsp_oob_o);
    end
    req_addr_i = 8'd220;
    tick();
    req_valid_i = 1'b0;
    checks++; if (rsp_data_o !== 8'hFF || rsp_oob_o !== 1'b1) begin
      errors++; $display("FAIL oob_220 got d=%h oob=%b exp d=ff oob=1", rsp_data_o, rsp_oob_o);
    end
    tick();
    $display("test_fill done");
  endtask

  task automatic test_backpressure();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i = 8'd1;
    tick();
    req_addr_i = 8'd2;
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_data_o !== 8'h90) begin
        errors++; $display("FAIL stall_cycle%0d got rdy=%b v=%b d=%h exp rdy=0 v=1 d=90", c, req_ready_o, rsp_valid_o, rsp_data_o);
      end
      tick();
    end
    rsp_ready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", req_ready_o); end
    tick();
    req_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 8'hC2) begin
      errors++; $display("FAIL after_release got v=%b d=%h exp v=1 d=c2", rsp_valid_o, rsp_data_o);
    end
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_run_write_ignored();
    do_write(0, 8'h00);
    m_mem[0] = 8'hC1;
    checks++; if (load_count_o !== 9'd4) begin errors++; $display("FAIL run_write_count got %0d exp 4", load_count_o); end
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i = 8'd0;
    tick();
    req_valid_i = 1'b0;
    checks++; if (rsp_data_o !== 8'hC1) begin errors++; $display("FAIL run_write_ignored got %h exp c1", rsp_data_o); end
    tick();
  endtask

  task automatic test_drain();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i = 8'd3;
    tick();
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_valid_i = 1'b1;
      #1;
      checks++; if (running_o !== 1'b0 || req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_data_o !== 8'h92) begin
        errors++; $display("FAIL drain_hold%0d got run=%b rdy=%b v=%b d=%h exp run=0 rdy=0 v=1 d=92", c, running_o, req_ready_o, rsp_valid_o, rsp_data_o);
      end
      tick();
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    model_clear();
    checks++; if (rsp_valid_o !== 1'b0 || running_o !== 1'b0 || load_count_o !== 9'd0) begin
      errors++; $display("FAIL drain_exit got v=%b run=%b cnt=%0d exp v=0 run=0 cnt=0", rsp_valid_o, running_o, load_count_o);
    end
    pulse_done();
    req_valid_i = 1'b1;
    req_addr_i = 8'd0;
    tick();
    req_valid_i = 1'b0;
    checks++; if (rsp_data_o !== 8'hFF) begin errors++; $display("FAIL reload_invalidated got %h exp ff", rsp_data_o); end
    tick();
    $display("test_drain done");
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) do_write(i, 8'(8'h30 + i));
    pulse_done();
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i = 8'd2;
    tick();
    req_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 8'h32) begin
      errors++; $display("FAIL pre_reset got v=%b d=%h exp v=1 d=32", rsp_valid_o, rsp_data_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++; if (rsp_valid_o !== 1'b0 || running_o !== 1'b0 || rsp_data_o !== 8'hFF) begin
      errors++; $display("FAIL async_reset got v=%b run=%b d=%h exp v=0 run=0 d=ff", rsp_valid_o, running_o, rsp_data_o);
    end
    tick();
    reset_i = 1'b0;
    model_clear();
    pulse_done();
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1;
      req_addr_i = 8'(i);
      tick();
      checks++; if (rsp_data_o !== 8'hFF) begin errors++; $display("FAIL post_reset addr %0d got %h exp ff", i, rsp_data_o); end
    end
    req_valid_i = 1'b0;
    tick();
    $display("test_async_reset done");
  endtask

  task automatic test_count_saturate();
    pulse_start();
    for (int i = 0; i < 270; i++) do_write($urandom_range(DEPTH, 255), 8'($urandom));
    checks++; if (load_count_o !== 9'd256) begin errors++; $display("FAIL count_saturate got %0d exp 256", load_count_o); end
    pulse_done();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i = 8'd0;
    tick();
    req_valid_i = 1'b0;
    checks++; if (rsp_data_o !== 8'hFF) begin errors++; $display("FAIL oob_write_dropped got %h exp ff", rsp_data_o); end
    tick();
    $display("test_count_saturate done");
  endtask

  task automatic test_random();
    int n;
    int exp_cnt;
    bit pend;
    bit exp_rdy;
    logic [7:0] pdata;
    bit poob;
    pulse_start();
    n = $urandom_range(60, 140);
    for (int i = 0; i < n; i++) do_write($urandom_range(0, 255), 8'($urandom));
    exp_cnt = (n > 256) ? 256 : n;
    checks++; if (load_count_o !== 9'(exp_cnt)) begin errors++; $display("FAIL rand_count got %0d exp %0d", load_count_o, exp_cnt); end
    pulse_done();
    pend = 1'b0;
    pdata = 8'hFF;
    poob = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req_valid_i = 1'($urandom_range(0, 1));
      req_addr_i = 8'($urandom_range(0, 255));
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !pend || rsp_ready_i;
      checks++; if (req_ready_o !== exp_rdy) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, req_ready_o, exp_rdy); end
      checks++; if (rsp_valid_o !== pend) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, rsp_valid_o, pend); end
      if (pend) begin
        checks++;
        if (rsp_data_o !== pdata || rsp_oob_o !== poob) begin
          errors++; $display("FAIL rand_rsp cyc %0d got d=%h oob=%b exp d=%h oob=%b", c, rsp_data_o, rsp_oob_o, pdata, poob);
        end
      end
      if (req_valid_i && exp_rdy) begin
        pdata = exp_word(int'(req_addr_i));
        poob = (int'(req_addr_i) >= DEPTH);
        pend = 1'b1;
      end else if (pend && rsp_ready_i) begin
        pend = 1'b0;
      end
      tick();
    end
    req_valid_i = 1'b0;
    $display("test_random done writes=%0d", n);
  endtask

  initial begin
    model_clear();
    #1;
    test_reset();
    test_load_fetch();
    test_fill();
    test_backpressure();
    test_run_write_ignored();
    test_drain();
    test_async_reset();
    test_count_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
